// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl
//   EX-stage issue/sequencing controller for RV32M ops. It sits directly
//   upstream of a combinational divider and multiplier. An accepted op has
//   its operands and opcode registered and held stable for a multicycle
//   path. The pipeline is stalled while the op is in flight. The selected
//   unit result is then captured and presented as a one-cycle writeback
//   beat.
//
// Parameters
//   DIV_LATENCY  BUSY cycles granted to the divider path    (>=1)
//   MUL_LATENCY  BUSY cycles granted to the multiplier path (>=1)
//
// Optional feature (compile-time macro MDU_EARLY_OUT_EN)
//   When defined, a div/rem with rs2_data==0 skips BUSY and goes straight to
//   DONE. Its result is all-ones for DIV/DIVU and the dividend for REM/REMU.
//   When undefined, every op takes the full BUSY path. The divide-by-zero
//   value then comes from the divider itself.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous, active-low reset
//   ex_valid    in   M-extension instruction present in EX
//   funct3      in   RV32M funct3; [2]=1 div/rem, [2]=0 mul
//   rs1_data    in   operand A
//   rs2_data    in   operand B
//   rd_addr     in   destination register
//   flush       in   kill in-flight op
//   div_opcode  out  latched funct3[1:0] to the divider
//   mul_opcode  out  latched funct3[1:0] to the multiplier
//   op_a, op_b  out  registered operands to both units
//   div_result  in   divider output
//   mul_result  in   multiplier output
//   stall       out  hold IF/ID/EX pipeline registers
//   wb_valid    out  one-cycle result beat
//   wb_rd       out  destination for wb_data
//   wb_data     out  registered result
//
// State | meaning
// IDLE  | waiting for an M op in EX; stall raised combinationally on accept
// BUSY  | operands held for the unit; cnt counts down to the sample cycle
// DONE  | wb_valid beat; the instruction leaves EX at the end of this cycle

module mdu_issue_ctrl #(
  parameter int DIV_LATENCY = 4,
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  input  logic        flush,
  output logic [1:0]  div_opcode,
  output logic [1:0]  mul_opcode,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic [31:0] div_result,
  input  logic [31:0] mul_result,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_LAT = (DIV_LATENCY > MUL_LATENCY) ? DIV_LATENCY : MUL_LATENCY;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CW-1:0] DIV_TC = CW'(DIV_LATENCY - 1);
  localparam logic [CW-1:0] MUL_TC = CW'(MUL_LATENCY - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic            accept;
  logic            capture;
  logic            early_out;
  logic [31:0]     early_data;

`ifdef MDU_EARLY_OUT_EN
  assign early_out  = funct3[2] & (rs2_data == 32'd0);
  assign early_data = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
`else
  assign early_out  = 1'b0;
  assign early_data = 32'd0;
`endif

  assign accept  = (state_q == IDLE) & ex_valid & ~flush;
  // Result is sampled only on the terminal count, so the units see operands
  // that have been stable for the full granted latency.
  assign capture = (state_q == BUSY) & ~flush & (cnt_q == '0);

  assign div_opcode = f3_q[1:0];
  assign mul_opcode = f3_q[1:0];

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    wb_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          stall   = 1'b1;
          state_d = early_out ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Op already committed: flush and ex_valid are ignored here.
        wb_valid = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= 3'd0;
      rd_q    <= 5'd0;
      op_a    <= 32'd0;
      op_b    <= 32'd0;
      wb_rd   <= 5'd0;
      wb_data <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a  <= rs1_data;
        op_b  <= rs2_data;
        f3_q  <= funct3;
        rd_q  <= rd_addr;
        cnt_q <= funct3[2] ? DIV_TC : MUL_TC;
        if (early_out) begin
          wb_data <= early_data;
          wb_rd   <= rd_addr;
        end
      end else if (capture) begin
        wb_data <= f3_q[2] ? div_result : mul_result;
        wb_rd   <= rd_q;
      end else if ((state_q == BUSY) && !flush) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule
